// File: rtl/temp_sample_accumulator.sv
// Sums a window of 2^SAMPLES_LOG2 unsigned temperature samples and offers the
// window sum downstream over a valid/ready handshake. The averaging stage shifts this sum to get the mean.
module temp_sample_accumulator #(
    parameter int DATA_WIDTH   = 26,
    parameter int SAMPLES_LOG2 = 6,
    parameter int SUM_WIDTH    = 32
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    clear,
    input  logic                    sample_valid,
    input  logic [DATA_WIDTH-1:0]   sample_in,
    output logic                    sample_ready,
    output logic                    sum_valid,
    output logic [SUM_WIDTH-1:0]    sum_out,
    input  logic                    sum_ready,
    output logic [SAMPLES_LOG2-1:0] sample_count
);

    typedef enum logic [0:0] {
        ACCUM = 1'b0,
        HOLD  = 1'b1
    } state_t;

    localparam logic [SAMPLES_LOG2-1:0] LAST_IDX = '1;

    state_t               state_r;
    logic [SUM_WIDTH-1:0] acc_r;
    logic [SUM_WIDTH-1:0] sample_ext_s;
    logic [SUM_WIDTH-1:0] acc_next_s;

    // SUM_WIDTH = DATA_WIDTH + SAMPLES_LOG2, so a full window of maximum samples cannot overflow.
    assign sample_ext_s = SUM_WIDTH'(sample_in);
    assign acc_next_s   = acc_r + sample_ext_s;

    // Window FSM. The handshake outputs are registered alongside the state so they always match it.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r      <= ACCUM;
            acc_r        <= '0;
            sample_count <= '0;
            sum_out      <= '0;
            sum_valid    <= 1'b0;
            sample_ready <= 1'b1;
        end else if (clear) begin
            state_r      <= ACCUM;
            acc_r        <= '0;
            sample_count <= '0;
            sum_valid    <= 1'b0;
            sample_ready <= 1'b1;
        end else begin
            case (state_r)
                ACCUM: begin
                    if (sample_valid && sample_ready) begin
                        if (sample_count == LAST_IDX) begin
                            sum_out      <= acc_next_s;
                            acc_r        <= '0;
                            sample_count <= '0;
                            state_r      <= HOLD;
                            sum_valid    <= 1'b1;
                            sample_ready <= 1'b0;
                        end else begin
                            acc_r        <= acc_next_s;
                            sample_count <= sample_count + SAMPLES_LOG2'(1);
                        end
                    end else begin
                        acc_r <= acc_r;
                    end
                end
                HOLD: begin
                    // Incoming samples are stalled by sample_ready=0; only the sum handshake matters here.
                    if (sum_ready) begin
                        state_r      <= ACCUM;
                        sum_valid    <= 1'b0;
                        sample_ready <= 1'b1;
                    end else begin
                        state_r <= HOLD;
                    end
                end
                default: begin
                    state_r      <= ACCUM;
                    acc_r        <= '0;
                    sample_count <= '0;
                    sum_valid    <= 1'b0;
                    sample_ready <= 1'b1;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_temp_sample_accumulator.sv
// Directed self-checking bench for temp_sample_accumulator.
module tb_temp_sample_accumulator;

    logic        clk = 1'b0;
    logic        rst;
    logic        clear;
    logic        sample_valid;
    logic [25:0] sample_in;
    logic        sample_ready;
    logic        sum_valid;
    logic [31:0] sum_out;
    logic        sum_ready;
    logic [5:0]  sample_count;

    int checks   = 0;
    int failures = 0;

    temp_sample_accumulator dut (
        .clk          (clk),
        .rst          (rst),
        .clear        (clear),
        .sample_valid (sample_valid),
        .sample_in    (sample_in),
        .sample_ready (sample_ready),
        .sum_valid    (sum_valid),
        .sum_out      (sum_out),
        .sum_ready    (sum_ready),
        .sample_count (sample_count)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    // One clock edge, then settle 1ns past it.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send(input logic [25:0] v);
        sample_valid = 1'b1;
        sample_in    = v;
        tick();
        sample_valid = 1'b0;
    endtask

    task automatic consume();
        sum_ready = 1'b1;
        tick();
        sum_ready = 1'b0;
        chk("consume_valid", {31'd0, sum_valid}, 32'd0);
        chk("consume_ready", {31'd0, sample_ready}, 32'd1);
    endtask

    initial begin
        rst = 1'b1; clear = 1'b0; sample_valid = 1'b0; sample_in = 26'd0; sum_ready = 1'b0;
        #2;
        chk("rst_count", {26'd0, sample_count}, 32'd0);
        chk("rst_sum", sum_out, 32'd0);
        chk("rst_valid", {31'd0, sum_valid}, 32'd0);
        chk("rst_ready", {31'd0, sample_ready}, 32'd1);
        tick();
        rst = 1'b0;
        tick();
        chk("post_rst_count", {26'd0, sample_count}, 32'd0);
        chk("post_rst_ready", {31'd0, sample_ready}, 32'd1);

        // 64 back-to-back samples of 100
        for (int i = 0; i < 64; i++) begin
            chk("count_seq", {26'd0, sample_count}, 32'(i));
            chk("no_early_valid", {31'd0, sum_valid}, 32'd0);
            send(26'd100);
        end
        chk("w100_valid", {31'd0, sum_valid}, 32'd1);
        chk("w100_sum", sum_out, 32'd6400);
        chk("w100_count_wrap", {26'd0, sample_count}, 32'd0);
        chk("w100_ready", {31'd0, sample_ready}, 32'd0);
        consume();

        // Maximum samples with idle gaps
        for (int i = 0; i < 64; i++) begin
            if ((i % 3) == 0) begin
                for (int g = 0; g < (i % 5) + 1; g++) tick();
            end
            send(26'h3FFFFFF);
        end
        chk("max_sum", sum_out, 32'hFFFFFFC0);
        chk("max_valid", {31'd0, sum_valid}, 32'd1);

        // Stall in HOLD while samples are offered
        sample_valid = 1'b1;
        sample_in    = 26'd50;
        for (int i = 0; i < 10; i++) begin
            tick();
            chk("hold_sum", sum_out, 32'hFFFFFFC0);
            chk("hold_ready", {31'd0, sample_ready}, 32'd0);
            chk("hold_valid", {31'd0, sum_valid}, 32'd1);
        end
        sample_valid = 1'b0;
        consume();
        chk("hold_no_consume", {26'd0, sample_count}, 32'd0);

        // Partial window aborted by clear with a concurrent sample
        for (int i = 0; i < 10; i++) send(26'd7);
        chk("partial_count", {26'd0, sample_count}, 32'd10);
        clear = 1'b1; sample_valid = 1'b1; sample_in = 26'd999;
        tick();
        clear = 1'b0; sample_valid = 1'b0;
        chk("clear_count", {26'd0, sample_count}, 32'd0);
        chk("clear_sum_kept", sum_out, 32'hFFFFFFC0);
        chk("clear_valid", {31'd0, sum_valid}, 32'd0);
        chk("clear_ready", {31'd0, sample_ready}, 32'd1);
        for (int i = 0; i < 64; i++) send(26'd1);
        chk("ones_sum", sum_out, 32'd64);
        chk("ones_valid", {31'd0, sum_valid}, 32'd1);
        consume();

        // Asynchronous reset mid-window
        for (int i = 0; i < 30; i++) send(26'(i));
        chk("mid_count", {26'd0, sample_count}, 32'd30);
        #2;
        rst = 1'b1;
        #1;
        chk("arst_count", {26'd0, sample_count}, 32'd0);
        chk("arst_sum", sum_out, 32'd0);
        chk("arst_ready", {31'd0, sample_ready}, 32'd1);
        tick();
        rst = 1'b0;
        for (int i = 0; i < 64; i++) send(26'(i));
        chk("ramp_sum", sum_out, 32'd2016);
        chk("ramp_valid", {31'd0, sum_valid}, 32'd1);

        // Asynchronous reset while holding a result
        #2;
        rst = 1'b1;
        #1;
        chk("arst_hold_valid", {31'd0, sum_valid}, 32'd0);
        chk("arst_hold_sum", sum_out, 32'd0);
        chk("arst_hold_ready", {31'd0, sample_ready}, 32'd1);
        tick();
        rst = 1'b0;
        for (int i = 0; i < 64; i++) send(26'(i));
        chk("ramp2_sum", sum_out, 32'd2016);

        // sum_ready and sample_valid together in HOLD
        sum_ready = 1'b1; sample_valid = 1'b1; sample_in = 26'd5;
        tick();
        sum_ready = 1'b0;
        chk("both_valid", {31'd0, sum_valid}, 32'd0);
        chk("both_count", {26'd0, sample_count}, 32'd0);
        chk("both_ready", {31'd0, sample_ready}, 32'd1);
        tick();
        sample_valid = 1'b0;
        chk("next_accept", {26'd0, sample_count}, 32'd1);
        for (int i = 0; i < 63; i++) send(26'd5);
        chk("fives_sum", sum_out, 32'd320);
        chk("fives_valid", {31'd0, sum_valid}, 32'd1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/temp_sample_accumulator.md
Name: temp_sample_accumulator

Overview:
- Collects a fixed window of 2^SAMPLES_LOG2 (default 64) temperature samples and produces their 32-bit running sum.
- The sum feeds the divide-by-64 averaging stage: the averaging path right-shifts this sum by 6 to get the mean temperature.
- Sits between the sensor sample source (valid/ready) and the averaging logic (valid/ready).

Parameters:
- DATA_WIDTH, 26, width of one unsigned temperature sample.
- SAMPLES_LOG2, 6, log2 of the window length; the window is 64 samples.
- SUM_WIDTH, 32, width of the sum. Must equal DATA_WIDTH+SAMPLES_LOG2, so the sum never overflows.

Ports:
- clk  input  1  rising-edge clock
- rst  input  1  asynchronous active-high reset
- clear  input  1  synchronous abort; discards the partial window or a pending result
- sample_valid  input  1  sample_in is valid this cycle
- sample_in  input  DATA_WIDTH  unsigned sample
- sample_ready  output  1  block accepts a sample this cycle
- sum_valid  output  1  sum_out holds a completed window sum
- sum_out  output  SUM_WIDTH  sum of the last 2^SAMPLES_LOG2 accepted samples
- sum_ready  input  1  downstream takes sum_out this cycle
- sample_count  output  SAMPLES_LOG2  samples accepted so far in the current window

Behaviour:
- **Reset.** rst takes effect immediately, regardless of clk. While rst is high and on release:
  - state=ACCUM, accumulator=0, sample_count=0
  - sum_out=0, sum_valid=0, sample_ready=1
- **States.**
  - ACCUM: sample_ready=1, sum_valid=0.
  - HOLD: sample_ready=0, sum_valid=1.
- **Accept in ACCUM.** A sample is accepted when sample_valid&&sample_ready at a clk edge. On acceptance:
  - the accumulator adds the zero-extended sample_in
  - sample_count increments
  - Cycles with sample_valid=0 change nothing; gaps are allowed.
- **Window complete.** On acceptance with sample_count==2^SAMPLES_LOG2-1:
  - sum_out <= accumulator+sample_in, registered
  - accumulator <= 0, sample_count <= 0 (wraps)
  - state <= HOLD
  - sum_valid is high the cycle after the 64th accept (latency 1).
- **HOLD.**
  - sum_out and sum_valid stay stable until sum_ready=1 at a clk edge; the state then returns to ACCUM and sum_valid=0 next cycle.
  - sample_valid is ignored in HOLD; no sample is accepted or lost, because ready=0.
  - sum_out keeps its last value after the handshake; it is only meaningful while sum_valid=1.
- **clear.** clear=1 at a clk edge has priority over every other event:
  - accumulator=0, sample_count=0, state=ACCUM, sum_valid=0
  - A sample presented in the same cycle is dropped, even though sample_ready was high.
  - sum_out is not changed.
- **Simultaneous events.**
  - In ACCUM, sum_ready has no effect.
  - In HOLD, sum_ready and sample_valid in the same cycle: only the sum handshake happens. The first sample of the next window can be accepted no earlier than the following cycle.
- **Arithmetic.** Unsigned only. The maximum sum is 64*(2^26-1)=0xFFFFFFC0 < 2^32, so there is no overflow or saturation logic.
- **Mid-operation reset.** An asserted rst discards the partial window and any pending sum immediately.

Test Plan:
- Reset, then 64 back-to-back samples of 100:
  - sum_valid rises the cycle after the 64th accept, sum_out=6400 (6400>>6=100)
  - sample_count reads 0..63 then wraps to 0.
- 64 samples of 0x3FFFFFF with random sample_valid gaps -> sum_out=0xFFFFFFC0. The gaps must not change the result.
- Complete a window, hold sum_ready=0 for 10 cycles while sample_valid=1:
  - sum_out stays constant, sample_ready=0
  - After sum_ready=1 for one cycle, sum_valid=0 and sample_ready=1, with no sample consumed during HOLD.
- Accept 10 samples of 7, pulse clear together with a valid sample of 999, then send 64 samples of 1:
  - sum_out=64
  - The 999 sample and the partial window are discarded.
- Assert rst asynchronously (between clk edges) after 30 samples, and again while in HOLD:
  - outputs go to reset values immediately
  - the next full window of samples 0..63 gives sum_out=2016.
- In HOLD, drive sum_ready and sample_valid together (value 5):
  - the sum is consumed, the 5 is not accepted
  - sample_count stays 0, and the next cycle accepts the sample.
